mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requesting caches (port 0 = Dcache, port 1 = Icache); legal range 2..8.
REQ-002 Parameter MAX_OUTSTANDING, default 4, max in-flight loads per port; legal range 1..15; CNT_W = clog2(MAX_OUTSTANDING+1).
REQ-003 clock  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 port2arb_command  input  NUM_PORTS x 2  per-port BUS_NONE/BUS_LOAD/BUS_STORE.
REQ-006 port2arb_addr  input  NUM_PORTS x XLEN  per-port address.
REQ-007 port2arb_data  input  NUM_PORTS x 64  per-port store data.
REQ-008 arb2port_response  output  NUM_PORTS x 4  per-port accept tag, 0 = not accepted.
REQ-009 arb2port_data  output  64  load data, broadcast to all ports.
REQ-010 arb2port_tag  output  NUM_PORTS x 4  per-port returning-data tag, 0 = none.
REQ-011 arb2port_outstanding  output  NUM_PORTS x CNT_W  per-port in-flight load count.
REQ-012 proc2mem_command / proc2mem_addr / proc2mem_data  output  2 / XLEN / 64  granted request to memory.
REQ-013 mem2proc_response / mem2proc_data / mem2proc_tag  input  4 / 64 / 4  memory accept tag (same cycle as command), data, data tag.
REQ-014 arb_err  output  1  sticky protocol-error flag.

Function
REQ-015 Eligible port: command != BUS_NONE and not (command == BUS_LOAD and outstanding == MAX_OUTSTANDING); stores never blocked by count.
REQ-016 Grant is combinational each cycle among eligible ports; no eligible port -> proc2mem_command = BUS_NONE, addr = 0, data = 0.
REQ-017 Granted port's command/addr/data drive memory; proc2mem_data = 0 unless granted command is BUS_STORE.
REQ-018 arb2port_response[g] = mem2proc_response for granted g, 0 for all other ports, same cycle.
REQ-019 Accepted = granted and mem2proc_response != 0; rejected request (response 0) records nothing; port retries next cycle.
REQ-020 Accepted load: owner table entry [mem2proc_response] <= {valid=1, port=g} at next posedge; outstanding[g] += 1.
REQ-021 Accepted store: no table entry, no count change.
REQ-022 mem2proc_tag != 0 with valid owner p: arb2port_tag[p] = mem2proc_tag same cycle, other ports 0; entry cleared and outstanding[p] -= 1 at posedge.
REQ-023 mem2proc_tag != 0 with no valid owner: all arb2port_tag = 0, data dropped, arb_err <= 1.
REQ-024 Accepted load tag already valid in table: entry overwritten with new owner, arb_err <= 1; displaced owner's count decremented.
REQ-025 Same cycle, returning tag == newly accepted tag: return routes to old owner and clears, then new owner recorded; net entry = new owner.
REQ-026 Same port, simultaneous accept and return: outstanding unchanged.
REQ-027 Owner table: 15 entries (tags 1..15); tag 0 never stored.
REQ-028 arb_err clears only on reset.

Reset
REQ-029 reset low at posedge: owner table invalid, all outstanding = 0, arb_err = 0, round-robin pointer = 0.
REQ-030 Reset mid-operation drops all in-flight ownership; later returns of those tags follow REQ-023.
REQ-031 Combinational outputs follow REQ-016/018/022 during reset with cleared state (outstanding = 0, no owners).

Configuration
REQ-032 Macro MEM_ARB_ROUND_ROBIN_EN defined: grant = first eligible port at or after pointer (wrapping modulo NUM_PORTS); pointer <= g+1 (wrapping) on acceptance only.
REQ-033 Macro undefined: fixed priority, lowest-index eligible port wins; no pointer state.

Verification
REQ-034 Fixed priority: port0 LOAD 0x100, port1 LOAD 0x200, response=3 -> proc2mem_addr=0x100, arb2port_response={3,0}; later mem2proc_tag=3 -> arb2port_tag[0]=3, tag[1]=0, outstanding[0] 1->0.
REQ-035 Round robin (macro on): both ports LOAD continuously, memory accepts every cycle -> grants alternate 0,1,0,1; with response=0 for 3 cycles grant stays on same port.
REQ-036 Throttle: MAX_OUTSTANDING=2, port1 issues 3 accepted-eligible LOADs, no returns -> third blocked, port0 STORE still granted; one return -> port1 eligible next cycle.
REQ-037 Errors: mem2proc_tag=7 with no owner -> all tags 0, arb_err=1 next cycle; accepted load tag 5 while 5 valid -> arb_err=1, owner updated.
REQ-038 Reset mid-flight: port0 holds tags 2,4, reset low one cycle -> outstanding=0, arb_err=0; subsequent mem2proc_tag=2 -> no port sees tag, arb_err=1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates cache requests onto a single memory port and routes returning load data by tag.
// Define MEM_ARB_ROUND_ROBIN_EN for a round-robin grant; otherwise the lowest-index eligible port wins.
module mem_arbiter #(
  parameter int  NUM_PORTS       = 2,
  parameter int  MAX_OUTSTANDING = 4,
  parameter int  XLEN            = 32,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_PORTS*2-1:0]     port2arb_command,
  input  logic [NUM_PORTS*XLEN-1:0]  port2arb_addr,
  input  logic [NUM_PORTS*64-1:0]    port2arb_data,
  output logic [NUM_PORTS*4-1:0]     arb2port_response,
  output logic [63:0]                arb2port_data,
  output logic [NUM_PORTS*4-1:0]     arb2port_tag,
  output logic [NUM_PORTS*CNT_W-1:0] arb2port_outstanding,
  output logic [1:0]                 proc2mem_command,
  output logic [XLEN-1:0]            proc2mem_addr,
  output logic [63:0]                proc2mem_data,
  input  logic [3:0]                 mem2proc_response,
  input  logic [63:0]                mem2proc_data,
  input  logic [3:0]                 mem2proc_tag,
  output logic                       arb_err
);

  localparam int PORT_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  logic [15:0]             valid_q, valid_d, valid_eff;
  logic [PORT_W-1:0]       owner_q [16];
  logic [CNT_W-1:0]        cnt_q [NUM_PORTS];
  logic [CNT_W-1:0]        cnt_d [NUM_PORTS];
  logic [CNT_W-1:0]        cnt_eff [NUM_PORTS];
  logic                    err_q, err_d;
  logic [NUM_PORTS-1:0]    eligible;
  logic                    grant_vld;
  logic [PORT_W-1:0]       grant;
  logic                    acc_load, accepted;
  logic                    ret_hit, disp;
  logic [PORT_W-1:0]       ret_port, disp_port;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [PORT_W-1:0]       ptr_q, ptr_d, ptr_eff;
  logic [2*NUM_PORTS-1:0]  rot;
  assign ptr_eff = reset ? ptr_q : '0;
`endif

  // While reset is held the outputs behave as if the state were already cleared.
  assign valid_eff     = reset ? valid_q : '0;
  assign arb2port_data = mem2proc_data;
  assign arb_err       = err_q;

  // NOTE: every variable gets a default at the top of each always_comb, so no path can infer a latch.
  always_comb begin
    eligible             = '0;
    arb2port_outstanding = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cnt_eff[p]  = reset ? cnt_q[p] : '0;
      eligible[p] = (port2arb_command[p*2 +: 2] != BUS_NONE) &&
                    !((port2arb_command[p*2 +: 2] == BUS_LOAD) &&
                      (cnt_eff[p] == CNT_W'(MAX_OUTSTANDING)));
      arb2port_outstanding[p*CNT_W +: CNT_W] = cnt_eff[p];
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Doubling the request vector lets a plain shift express the wrap-around search.
    rot = {eligible, eligible} >> ptr_eff;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_vld = 1'b1;
        grant     = PORT_W'((int'(ptr_eff) + i) % NUM_PORTS);
      end
    end
`else
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (eligible[p]) begin
        grant_vld = 1'b1;
        grant     = PORT_W'(p);
      end
    end
`endif
  end

  always_comb begin
    proc2mem_command  = BUS_NONE;
    proc2mem_addr     = '0;
    proc2mem_data     = '0;
    arb2port_response = '0;
    arb2port_tag      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_vld && grant == PORT_W'(p)) begin
        proc2mem_command             = port2arb_command[p*2 +: 2];
        proc2mem_addr                = port2arb_addr[p*XLEN +: XLEN];
        proc2mem_data                = (port2arb_command[p*2 +: 2] == BUS_STORE) ?
                                       port2arb_data[p*64 +: 64] : '0;
        arb2port_response[p*4 +: 4]  = mem2proc_response;
      end
      if (ret_hit && ret_port == PORT_W'(p))
        arb2port_tag[p*4 +: 4] = mem2proc_tag;
    end
  end

  assign accepted  = grant_vld && (mem2proc_response != 4'd0);
  assign acc_load  = accepted && (proc2mem_command == BUS_LOAD);
  assign ret_hit   = (mem2proc_tag != 4'd0) && valid_eff[mem2proc_tag];
  assign ret_port  = owner_q[mem2proc_tag];
  // A same-cycle return of the accepted tag frees the entry first, so it is not a displacement.
  assign disp      = acc_load && valid_eff[mem2proc_response] &&
                     !(ret_hit && mem2proc_tag == mem2proc_response);
  assign disp_port = owner_q[mem2proc_response];

  always_comb begin
    valid_d = valid_eff;
    err_d   = err_q;
    if (mem2proc_tag != 4'd0) begin
      if (ret_hit) valid_d[mem2proc_tag] = 1'b0;
      else         err_d = 1'b1;
    end
    if (acc_load) begin
      valid_d[mem2proc_response] = 1'b1;
      if (disp) err_d = 1'b1;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      cnt_d[p] = cnt_eff[p]
               + CNT_W'(acc_load && grant == PORT_W'(p))
               - CNT_W'(ret_hit && ret_port == PORT_W'(p))
               - CNT_W'(disp && disp_port == PORT_W'(p));
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_d = ptr_eff;
    if (accepted)
      ptr_d = (grant == PORT_W'(NUM_PORTS - 1)) ? '0 : grant + PORT_W'(1);
`endif
  end

  // NOTE: state registers are written with non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= cnt_d[p];
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // NOTE: the owner field array is not reset; valid_q alone decides whether an entry is meaningful.
  always_ff @(posedge clock) begin
    if (reset && acc_load) owner_q[mem2proc_response] <= grant;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (2 ports, MAX_OUTSTANDING = 2); expectations adapt to MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clock, reset;
  logic [3:0]   cmd;
  logic [63:0]  addr;
  logic [127:0] pdata;
  logic [7:0]   resp_o;
  logic [63:0]  a2p_data;
  logic [7:0]   a2p_tag;
  logic [3:0]   outst;
  logic [1:0]   p2m_cmd;
  logic [31:0]  p2m_addr;
  logic [63:0]  p2m_data;
  logic [3:0]   mem_resp;
  logic [63:0]  mem_data;
  logic [3:0]   mem_tag;
  logic         err;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.NUM_PORTS(2), .MAX_OUTSTANDING(2), .XLEN(32)) dut (
    .clock                (clock),
    .reset                (reset),
    .port2arb_command     (cmd),
    .port2arb_addr        (addr),
    .port2arb_data        (pdata),
    .arb2port_response    (resp_o),
    .arb2port_data        (a2p_data),
    .arb2port_tag         (a2p_tag),
    .arb2port_outstanding (outst),
    .proc2mem_command     (p2m_cmd),
    .proc2mem_addr        (p2m_addr),
    .proc2mem_data        (p2m_data),
    .mem2proc_response    (mem_resp),
    .mem2proc_data        (mem_data),
    .mem2proc_tag         (mem_tag),
    .arb_err              (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Apply both ports' command/address plus memory response and return tag, then let logic settle.
  task automatic drive(input logic [1:0] c0, input logic [31:0] a0,
                       input logic [1:0] c1, input logic [31:0] a1,
                       input logic [3:0] r, input logic [3:0] t);
    cmd      = {c1, c0};
    addr     = {a1, a0};
    mem_resp = r;
    mem_tag  = t;
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    pdata    = '0;
    mem_data = '0;
    drive(2'd0, 32'h0, 2'd0, 32'h0, 4'd0, 4'd0);
    tick();
    tick();
    check("reset_outst", outst, 4'h0);
    check("reset_err", err, 1'b0);
    check("idle_cmd", p2m_cmd, 2'd0);
    check("idle_addr", p2m_addr, 32'h0);
    reset = 1'b1;

    // Both ports load; port 0 wins after reset in either arbitration mode.
    drive(2'd1, 32'h100, 2'd1, 32'h200, 4'd3, 4'd0);
    check("fp_addr", p2m_addr, 32'h100);
    check("fp_cmd", p2m_cmd, 2'd1);
    check("fp_load_data", p2m_data, 64'h0);
    check("fp_resp", resp_o, 8'h03);
    tick();
    check("fp_outst_inc", outst, 4'b0001);
    mem_data = 64'hDEAD_BEEF_0123_4567;
    drive(2'd0, 32'h0, 2'd0, 32'h0, 4'd0, 4'd3);
    check("fp_ret_tag", a2p_tag, 8'h03);
    check("ret_data", a2p_data, 64'hDEAD_BEEF_0123_4567);
    tick();
    check("fp_outst_dec", outst, 4'b0000);
    check("fp_no_err", err, 1'b0);

    // Store from port 1: rejected once, then accepted; no count change.
    pdata = {64'hCAFE_F00D_1111_2222, 64'h0};
    drive(2'd0, 32'h0, 2'd2, 32'h240, 4'd0, 4'd0);
    check("st_cmd", p2m_cmd, 2'd2);
    check("st_data", p2m_data, 64'hCAFE_F00D_1111_2222);
    check("st_rej_resp", resp_o, 8'h00);
    tick();
    drive(2'd0, 32'h0, 2'd2, 32'h240, 4'd6, 4'd0);
    check("st_acc_resp", resp_o, 8'h60);
    tick();
    check("st_outst", outst, 4'b0000);
    pdata = '0;

    // Arbitration order with both ports loading.
    drive(2'd1, 32'h100, 2'd1, 32'h200, 4'd1, 4'd0);
    check("arb_a", p2m_addr, 32'h100);
    tick();
    drive(2'd1, 32'h100, 2'd1, 32'h200, 4'd2, 4'd0);
    check("arb_b", p2m_addr, RR ? 32'h200 : 32'h100);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(2'd1, 32'h100, 2'd1, 32'h200, 4'd0, 4'd0);
      check("arb_hold", p2m_addr, RR ? 32'h100 : 32'h200);
      tick();
    end
    drive(2'd0, 32'h0, 2'd0, 32'h0, 4'd0, 4'd1);
    check("arb_ret1", a2p_tag, 8'h01);
    tick();
    drive(2'd0, 32'h0, 2'd0, 32'h0, 4'd0, 4'd2);
    check("arb_ret2", a2p_tag, RR ? 8'h20 : 8'h02);
    tick();
    check("arb_outst", outst, 4'b0000);

    // Throttle: port 1 reaches two loads in flight and is blocked.
    drive(2'd0, 32'h0, 2'd1, 32'h200, 4'd4, 4'd0);
    check("thr_resp1", resp_o, 8'h40);
    tick();
    drive(2'd0, 32'h0, 2'd1, 32'h200, 4'd5, 4'd0);
    tick();
    check("thr_outst2", outst, 4'b1000);
    pdata = {64'h0, 64'h0000_0000_5555_AAAA};
    drive(2'd2, 32'h400, 2'd1, 32'h200, 4'd6, 4'd0);
    check("thr_store_cmd", p2m_cmd, 2'd2);
    check("thr_store_addr", p2m_addr, 32'h400);
    check("thr_store_resp", resp_o, 8'h06);
    tick();
    pdata = '0;
    drive(2'd0, 32'h0, 2'd1, 32'h200, 4'd6, 4'd0);
    check("thr_blocked_cmd", p2m_cmd, 2'd0);
    check("thr_blocked_resp", resp_o, 8'h00);
    tick();
    drive(2'd0, 32'h0, 2'd1, 32'h200, 4'd0, 4'd4);
    check("thr_still_blocked", p2m_cmd, 2'd0);
    check("thr_ret_tag", a2p_tag, 8'h40);
    tick();
    check("thr_outst1", outst, 4'b0100);
    drive(2'd0, 32'h0, 2'd1, 32'h200, 4'd8, 4'd0);
    check("thr_unblocked", p2m_cmd, 2'd1);
    check("thr_unblk_resp", resp_o, 8'h80);
    tick();
    check("thr_outst_back", outst, 4'b1000);

    // Port 0 load takes tag 5 still owned by port 1.
    drive(2'd1, 32'h300, 2'd0, 32'h0, 4'd5, 4'd0);
    check("ow_resp", resp_o, 8'h05);
    check("ow_err_before", err, 1'b0);
    tick();
    check("ow_err", err, 1'b1);
    check("ow_outst", outst, 4'b0101);
    drive(2'd0, 32'h0, 2'd0, 32'h0, 4'd0, 4'd5);
    check("ow_new_owner", a2p_tag, 8'h05);
    tick();
    check("ow_outst_after", outst, 4'b0100);

    // Return of tag 8 to port 1 while port 0 is granted tag 8 in the same cycle.
    drive(2'd1, 32'h300, 2'd0, 32'h0, 4'd8, 4'd8);
    check("same_tag_ret", a2p_tag, 8'h80);
    check("same_tag_resp", resp_o, 8'h08);
    tick();
    check("same_tag_outst", outst, 4'b0001);
    drive(2'd1, 32'h300, 2'd0, 32'h0, 4'd9, 4'd8);
    check("same_port_ret", a2p_tag, 8'h08);
    tick();
    check("same_port_outst", outst, 4'b0001);
    drive(2'd1, 32'h300, 2'd0, 32'h0, 4'd2, 4'd9);
    tick();
    drive(2'd1, 32'h300, 2'd0, 32'h0, 4'd4, 4'd0);
    tick();
    check("pre_rst_outst", outst, 4'b0010);

    // Reset for one cycle while port 0 holds tags 2 and 4.
    reset = 1'b0;
    drive(2'd1, 32'h100, 2'd0, 32'h0, 4'd3, 4'd0);
    check("rst_comb_resp", resp_o, 8'h03);
    check("rst_comb_outst", outst, 4'b0000);
    tick();
    reset = 1'b1;
    drive(2'd0, 32'h0, 2'd0, 32'h0, 4'd0, 4'd0);
    check("rst_outst", outst, 4'b0000);
    check("rst_err", err, 1'b0);
    drive(2'd0, 32'h0, 2'd0, 32'h0, 4'd0, 4'd2);
    check("orphan_tag", a2p_tag, 8'h00);
    tick();
    check("orphan_err", err, 1'b1);
    drive(2'd0, 32'h0, 2'd0, 32'h0, 4'd0, 4'd0);
    tick();
    check("err_sticky", err, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
